// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions,
// the iterative-datapath mode encoding and the control FSM state type.
// Latency: n/a (definitions only). Backpressure: n/a.
package alu_seq_pkg;

  // ALUControl opcodes
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_ORR  = 3'b011;
  localparam logic [2:0] OP_UMUL = 3'b100;
  localparam logic [2:0] OP_UDIV = 3'b101;
  localparam logic [2:0] OP_EOR  = 3'b110;
  localparam logic [2:0] OP_MOV  = 3'b111;

  // Bit positions inside ALUFlags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Iterative datapath mode
  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv.sv
// Shared iterative shift-register datapath: shift-add multiply or restoring divide.
// Latency: one step per cycle while run=1; WIDTH steps per operation; *_nxt are the post-step values.
// Backpressure: none; the controlling FSM decides when to load and step.
//
// Ports: clk, reset (async, active-high), load (capture a/b, clear accumulator
// and counter), run (perform one step), mode (MODE_MUL/MODE_DIV), a, b,
// acc_nxt/sh_nxt (accumulator and shift register after the current step),
// last (the current step is the final one).
// Divide stepping is only built when ALU_SEQ_DIV_EN is defined.
module alu_muldiv
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] sh_nxt,
  output logic             last
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  // acc: product high half / partial remainder
  // sh : multiplier being consumed into product low half / dividend becoming quotient
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   mul_sum;
`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      sh   <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= '0;
      sh   <= a;
      opnd <= b;
      cnt  <= '0;
    end else if (run) begin
      acc  <= acc_nxt;
      sh   <= sh_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_comb begin
    // Multiply: conditionally add multiplicand, then shift {acc,sh} right by one,
    // the carry-out landing in the top of acc.
    mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    acc_nxt = mul_sum[WIDTH:1];
    sh_nxt  = {mul_sum[0], sh[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Divide: bring the next dividend bit into the remainder, subtract the
    // divisor when it fits and shift the resulting quotient bit into sh.
    // When div_ge holds the true difference is below opnd, so the low WIDTH
    // bits of the subtraction are exact.
    div_rem  = {acc, sh[WIDTH-1]};
    div_ge   = (div_rem >= {1'b0, opnd});
    div_diff = div_rem[WIDTH-1:0] - opnd;
    if (mode == MODE_DIV) begin
      acc_nxt = div_ge ? div_diff : div_rem[WIDTH-1:0];
      sh_nxt  = {sh[WIDTH-2:0], div_ge};
    end
`else
    if (mode == MODE_DIV) begin
      acc_nxt = acc;
      sh_nxt  = sh;
    end
`endif
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ADD/SUB/AND/ORR/EOR/MOV plus iterative UMUL/UDIV.
// Latency: 1 cycle for single-cycle ops (back-to-back accepted), WIDTH+1 for iterative ops.
// Backpressure: busy=1 during iteration; start is ignored while busy (no queueing).
//
// Ports: clk, reset (async, active-high), start, a, b, ALUControl (opcode),
// busy, done (one-cycle pulse), Result, Auxiliar (product high / remainder),
// ALUFlags {N,Z,C,V}.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise opcode 101 is a
// single-cycle op returning zero.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Auxiliar,
  output logic [3:0]       ALUFlags
);

  state_t state, state_nxt;

  logic             div_iter;
  logic             iter_op;
  logic             load;
  logic             run;
  logic             sc_load;
  logic             fin_load;
  logic             mode_q;

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_aux;
  logic             sc_c;
  logic             sc_v;
  logic [3:0]       sc_flags;
  logic [3:0]       it_flags;

  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sh_nxt;
  logic             last;

  // A zero divisor never iterates; it is answered by the single-cycle path.
`ifdef ALU_SEQ_DIV_EN
  assign div_iter = (ALUControl == OP_UDIV) && (b != '0);
`else
  assign div_iter = 1'b0;
`endif
  assign iter_op = (ALUControl == OP_UMUL) || div_iter;

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .run     (run),
    .mode    (mode_q),
    .a       (a),
    .b       (b),
    .acc_nxt (acc_nxt),
    .sh_nxt  (sh_nxt),
    .last    (last)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and control strobes. FIN behaves like IDLE for accepting
  // a new start, so a new operation can issue in the completion cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    run       = 1'b0;
    sc_load   = 1'b0;
    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (start) begin
          if (iter_op) begin
            state_nxt = ITER;
            load      = 1'b1;
          end else begin
            sc_load   = 1'b1;
          end
        end
      end
      ITER: begin
        run = 1'b1;
        if (last) state_nxt = FIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state == ITER);
  assign fin_load = run && last;

  // Single-cycle results; SUB is a + ~b + 1 so C means "no borrow".
  always_comb begin
    is_sub  = (ALUControl == OP_SUB);
    b_op    = is_sub ? ~b : b;
    add_sum = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    sc_res  = '0;
    sc_aux  = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b_op[WIDTH-1]) && (add_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: sc_res = a & b;
      OP_ORR: sc_res = a | b;
      OP_EOR: sc_res = a ^ b;
      OP_MOV: sc_res = b;
`ifdef ALU_SEQ_DIV_EN
      // Only reached with b == 0 (non-zero divisors iterate).
      OP_UDIV: begin
        sc_res = '1;
        sc_aux = a;
        sc_v   = 1'b1;
      end
`endif
      default: ;
    endcase
    sc_flags         = '0;
    sc_flags[FLAG_N] = sc_res[WIDTH-1];
    sc_flags[FLAG_Z] = (sc_res == '0);
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_V] = sc_v;
  end

  // Iterative flags from the final-step values; multiply reports on the whole
  // 2*WIDTH product, divide on the quotient.
  always_comb begin
    it_flags = '0;
    if (mode_q == MODE_MUL) begin
      it_flags[FLAG_N] = acc_nxt[WIDTH-1];
      it_flags[FLAG_Z] = ({acc_nxt, sh_nxt} == '0);
    end else begin
      it_flags[FLAG_N] = sh_nxt[WIDTH-1];
      it_flags[FLAG_Z] = (sh_nxt == '0);
    end
  end

  // Output registers hold until the next accepted operation completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      mode_q   <= MODE_MUL;
      Result   <= '0;
      Auxiliar <= '0;
      ALUFlags <= '0;
    end else begin
      done <= sc_load || fin_load;
      if (load) mode_q <= (ALUControl == OP_UDIV) ? MODE_DIV : MODE_MUL;
      if (sc_load) begin
        Result   <= sc_res;
        Auxiliar <= sc_aux;
        ALUFlags <= sc_flags;
      end else if (fin_load) begin
        Result   <= sh_nxt;
        Auxiliar <= acc_nxt;
        ALUFlags <= it_flags;
      end
    end
  end

endmodule
